alu_top: RTL and testbench
==========================

# alu_top

Registered 8-bit, four-unit ALU (arithmetic, logic, compare, shift) with a 4-bit function code. ALU_FUN[3:2] selects one unit; ALU_FUN[1:0] selects that unit's operation. Every output is registered on CLK, and each unit drives its own 16-bit result bus and a one-hot "valid" flag. The block is a leaf datapath element fed by a controller that holds operands and function stable across a clock edge.

## Interface
- in_width, default 8: operand width.
- out_width, default 16: result width; must be ≥ 2·in_width.

- CLK  input  1  clock; all state updates on rising edge.
- RST  input  1  reset: synchronous, active-high.
- A  input  in_width  operand A, unsigned.
- B  input  in_width  operand B, unsigned.
- ALU_FUN  input  4  function code.
- Arith_OUT  output  out_width  arithmetic result.
- Carry_OUT  output  1  arithmetic carry/borrow/error bit.
- Arith_Flag  output  1  high when Arith_OUT holds a fresh result.
- Logic_OUT  output  out_width  logic result.
- Logic_Flag  output  1  logic result valid.
- CMP_OUT  output  out_width  compare result code.
- CMP_Flag  output  1  compare result valid.
- SHIFT_OUT  output  out_width  shift result.
- SHIFT_Flag  output  1  shift result valid.

## Operation
Operands are zero-extended to out_width before every operation.

**Unit decode (ALU_FUN[3:2]):**
- 00 = arith
- 01 = logic
- 10 = cmp
- 11 = shift

**Arith (00xx):**
- 00: A+B. Carry_OUT = bit in_width of the sum; the full sum also appears in Arith_OUT.
- 01: A−B, two's complement in out_width. Carry_OUT = 1 when A<B (borrow).
- 10: A·B. Carry_OUT = 0.
- 11: A/B, integer quotient, Carry_OUT = 0. When B=0: Arith_OUT = all ones (65535), Carry_OUT = 1.

**Logic (01xx):**
- 00: A&B
- 01: A|B
- 10: ~(A&B)
- 11: ~(A|B)
- Inversion is over out_width bits, e.g. NAND(50,15) = 0xFFFD.

**Cmp (10xx):**
- 00: 0
- 01: 1 if A==B, else 0
- 10: 2 if A>B, else 0
- 11: 3 if A<B, else 0

**Shift (11xx):**
- 00: A>>1
- 01: A<<1
- 10: B>>1
- 11: B<<1
- Logical shifts; the shifted-out MSB is retained in bit in_width, e.g. 255<<1 = 510.

**Non-selected units:** on each clock edge, every non-selected unit's OUT and Flag are loaded with 0. Carry_OUT is loaded with 0 whenever arith is not selected. Exactly one Flag is high after any non-reset edge.

## Timing
- Latency is 1 cycle: inputs sampled at a rising edge appear at the outputs after that edge and are held until the next edge.
- Reset: RST=1 at a rising edge clears all OUT buses, all Flags and Carry_OUT to 0. Reset takes priority over any function code.
- Reset mid-operation discards the pending operation. The first edge with RST=0 computes from the current inputs.
- Inputs changing between edges have no effect on the outputs. There is no handshake; the result is valid on the flag in every cycle.
- Divide and multiply are combinational within one cycle; no multi-cycle path is allowed.

## Configuration
- ALU_DIVIDE_EN defined: ALU_FUN=0011 performs division as specified above.
- ALU_DIVIDE_EN undefined: no divider is synthesized. ALU_FUN=0011 yields Arith_OUT=0 and Carry_OUT=0, with Arith_Flag=1.

## Test plan
- Reset and basic arithmetic:
  - RST=1 for one edge → all outputs 0.
  - Then A=15, B=30, FUN=0000 → Arith_OUT=45, Arith_Flag=1, Carry_OUT=0, other flags 0.
- Arithmetic corners:
  - 50−15 → 35.
  - 50·15 → 750.
  - 255·255 → 65025.
  - 255+255 → 510, Carry_OUT=1.
  - 50/5 → 10.
  - 50/0 → 65535, Carry_OUT=1 (with ALU_DIVIDE_EN).
- Logic:
  - 15&30 → 14.
  - 50|15 → 63.
  - NAND(50,15) → 0xFFFD.
  - NOR(50,5) → 0xFFC8.
  - NAND(255,255) → 0xFF00.
  - Logic_Flag=1, Arith_OUT=0.
- Compare:
  - 1001 with 50,50 → 1; with 25,23 → 0.
  - 1010 with 50,15 → 2; with 240,245 → 0.
  - 1011 with 10,50 → 3; with 50,5 → 0.
  - 1000 → 0.
- Shift:
  - 1100 A=40 → 20; A=255 → 127.
  - 1101 A=50 → 100; A=255 → 510.
  - 1110 B=80 → 40.
  - 1111 B=5 → 10; B=255 → 510.
- Reset mid-stream: assert RST during FUN=0010 → next edge all outputs 0. Deassert → 750 one edge later.

Source files
------------

// File: rtl/alu_top.sv
// Registered four-unit ALU: arith, logic, compare, shift; one-hot unit flags.
// Define ALU_DIVIDE_EN to build the combinational divider for ALU_FUN=0011.
module alu_top #(
  parameter int in_width  = 8,
  parameter int out_width = 16
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic [in_width-1:0]  A,
  input  logic [in_width-1:0]  B,
  input  logic [3:0]           ALU_FUN,
  output logic [out_width-1:0] Arith_OUT,
  output logic                 Carry_OUT,
  output logic                 Arith_Flag,
  output logic [out_width-1:0] Logic_OUT,
  output logic                 Logic_Flag,
  output logic [out_width-1:0] CMP_OUT,
  output logic                 CMP_Flag,
  output logic [out_width-1:0] SHIFT_OUT,
  output logic                 SHIFT_Flag
);

  localparam int PAD = out_width - in_width;

  logic [out_width-1:0] w_a;
  logic [out_width-1:0] w_b;
  logic [out_width-1:0] w_sum;
  logic [out_width-1:0] w_arith;
  logic                 w_carry;
  logic [out_width-1:0] w_logic;
  logic [out_width-1:0] w_cmp;
  logic [out_width-1:0] w_shift;

  logic [out_width-1:0] r_arith;
  logic                 r_carry;
  logic                 r_arith_flag;
  logic [out_width-1:0] r_logic;
  logic                 r_logic_flag;
  logic [out_width-1:0] r_cmp;
  logic                 r_cmp_flag;
  logic [out_width-1:0] r_shift;
  logic                 r_shift_flag;

  assign w_a   = {{PAD{1'b0}}, A};
  assign w_b   = {{PAD{1'b0}}, B};
  assign w_sum = w_a + w_b;

  always_comb begin
    w_arith = '0;
    w_carry = 1'b0;
    unique case (ALU_FUN[1:0])
      2'b00: begin
        w_arith = w_sum;
        w_carry = w_sum[in_width];
      end
      2'b01: begin
        w_arith = w_a - w_b;
        w_carry = (A < B);
      end
      2'b10: w_arith = w_a * w_b;
      2'b11: begin
`ifdef ALU_DIVIDE_EN
        // Divide by zero saturates and raises the error bit
        if (B == '0) begin
          w_arith = '1;
          w_carry = 1'b1;
        end else begin
          w_arith = w_a / w_b;
        end
`else
        w_arith = '0;
`endif
      end
    endcase
  end

  always_comb begin
    w_logic = '0;
    unique case (ALU_FUN[1:0])
      2'b00: w_logic = w_a & w_b;
      2'b01: w_logic = w_a | w_b;
      2'b10: w_logic = ~(w_a & w_b);
      2'b11: w_logic = ~(w_a | w_b);
    endcase
  end

  always_comb begin
    w_cmp = '0;
    unique case (ALU_FUN[1:0])
      2'b00: w_cmp = '0;
      2'b01: w_cmp = (A == B) ? out_width'(1) : '0;
      2'b10: w_cmp = (A > B)  ? out_width'(2) : '0;
      2'b11: w_cmp = (A < B)  ? out_width'(3) : '0;
    endcase
  end

  always_comb begin
    w_shift = '0;
    unique case (ALU_FUN[1:0])
      2'b00: w_shift = w_a >> 1;
      2'b01: w_shift = w_a << 1;
      2'b10: w_shift = w_b >> 1;
      2'b11: w_shift = w_b << 1;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_arith      <= '0;
      r_carry      <= 1'b0;
      r_arith_flag <= 1'b0;
      r_logic      <= '0;
      r_logic_flag <= 1'b0;
      r_cmp        <= '0;
      r_cmp_flag   <= 1'b0;
      r_shift      <= '0;
      r_shift_flag <= 1'b0;
    end else begin
      r_arith      <= '0;
      r_carry      <= 1'b0;
      r_arith_flag <= 1'b0;
      r_logic      <= '0;
      r_logic_flag <= 1'b0;
      r_cmp        <= '0;
      r_cmp_flag   <= 1'b0;
      r_shift      <= '0;
      r_shift_flag <= 1'b0;
      unique case (ALU_FUN[3:2])
        2'b00: begin
          r_arith      <= w_arith;
          r_carry      <= w_carry;
          r_arith_flag <= 1'b1;
        end
        2'b01: begin
          r_logic      <= w_logic;
          r_logic_flag <= 1'b1;
        end
        2'b10: begin
          r_cmp      <= w_cmp;
          r_cmp_flag <= 1'b1;
        end
        2'b11: begin
          r_shift      <= w_shift;
          r_shift_flag <= 1'b1;
        end
      endcase
    end
  end

  assign Arith_OUT  = r_arith;
  assign Carry_OUT  = r_carry;
  assign Arith_Flag = r_arith_flag;
  assign Logic_OUT  = r_logic;
  assign Logic_Flag = r_logic_flag;
  assign CMP_OUT    = r_cmp;
  assign CMP_Flag   = r_cmp_flag;
  assign SHIFT_OUT  = r_shift;
  assign SHIFT_Flag = r_shift_flag;

endmodule

// File: tb/tb_alu_top.sv
// Bench for alu_top: directed spec cases plus randomized ops vs an
// arithmetic reference model. Honors ALU_DIVIDE_EN like the design.
module tb_alu_top;

  logic        CLK;
  logic        RST;
  logic [7:0]  A;
  logic [7:0]  B;
  logic [3:0]  ALU_FUN;
  logic [15:0] Arith_OUT;
  logic        Carry_OUT;
  logic        Arith_Flag;
  logic [15:0] Logic_OUT;
  logic        Logic_Flag;
  logic [15:0] CMP_OUT;
  logic        CMP_Flag;
  logic [15:0] SHIFT_OUT;
  logic        SHIFT_Flag;

  int tests;
  int fails;

  alu_top #(.in_width(8), .out_width(16)) dut (
    .CLK       (CLK),
    .RST       (RST),
    .A         (A),
    .B         (B),
    .ALU_FUN   (ALU_FUN),
    .Arith_OUT (Arith_OUT),
    .Carry_OUT (Carry_OUT),
    .Arith_Flag(Arith_Flag),
    .Logic_OUT (Logic_OUT),
    .Logic_Flag(Logic_Flag),
    .CMP_OUT   (CMP_OUT),
    .CMP_Flag  (CMP_Flag),
    .SHIFT_OUT (SHIFT_OUT),
    .SHIFT_Flag(SHIFT_Flag)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input int got, input int exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Reference: expected[0..3] = arith/logic/cmp/shift result, per-unit flags
  task automatic model(input bit rst, input int a, input int b,
                       input int f, output int res[4],
                       output int flg[4], output int cy);
    int unit;
    int op;
    unit = f / 4;
    op   = f % 4;
    for (int i = 0; i < 4; i++) begin
      res[i] = 0;
      flg[i] = 0;
    end
    cy = 0;
    if (rst) return;
    flg[unit] = 1;
    case (unit)
      0: case (op)
        0: begin res[0] = a + b; cy = (a + b > 255) ? 1 : 0; end
        1: begin res[0] = (a - b + 65536) % 65536; cy = (a < b) ? 1 : 0; end
        2: res[0] = a * b;
        default: begin
`ifdef ALU_DIVIDE_EN
          if (b == 0) begin res[0] = 65535; cy = 1; end
          else res[0] = a / b;
`else
          res[0] = 0;
`endif
        end
      endcase
      1: case (op)
        0: res[1] = a & b;
        1: res[1] = a | b;
        2: res[1] = 65535 - (a & b);
        default: res[1] = 65535 - (a | b);
      endcase
      2: case (op)
        0: res[2] = 0;
        1: res[2] = (a == b) ? 1 : 0;
        2: res[2] = (a > b) ? 2 : 0;
        default: res[2] = (a < b) ? 3 : 0;
      endcase
      default: case (op)
        0: res[3] = a / 2;
        1: res[3] = a * 2;
        2: res[3] = b / 2;
        default: res[3] = b * 2;
      endcase
    endcase
  endtask

  task automatic step(input bit rst, input int a, input int b, input int f);
    int res[4];
    int flg[4];
    int cy;
    RST     = rst;
    A       = a[7:0];
    B       = b[7:0];
    ALU_FUN = f[3:0];
    @(posedge CLK);
    #1;
    model(rst, a, b, f, res, flg, cy);
    chk("arith_out", int'(Arith_OUT), res[0]);
    chk("logic_out", int'(Logic_OUT), res[1]);
    chk("cmp_out", int'(CMP_OUT), res[2]);
    chk("shift_out", int'(SHIFT_OUT), res[3]);
    chk("arith_flag", int'(Arith_Flag), flg[0]);
    chk("logic_flag", int'(Logic_Flag), flg[1]);
    chk("cmp_flag", int'(CMP_Flag), flg[2]);
    chk("shift_flag", int'(SHIFT_Flag), flg[3]);
    chk("carry", int'(Carry_OUT), cy);
    chk("onehot", $countones({Arith_Flag, Logic_Flag, CMP_Flag, SHIFT_Flag}),
        rst ? 0 : 1);
  endtask

  initial begin
    tests   = 0;
    fails   = 0;
    RST     = 1'b1;
    A       = '0;
    B       = '0;
    ALU_FUN = '0;

    step(1, 200, 100, 4'b0110);
    chk("rst_arith", int'(Arith_OUT), 0);
    step(0, 15, 30, 4'b0000);
    chk("add45", int'(Arith_OUT), 45);
    step(0, 50, 15, 4'b0001);
    chk("sub35", int'(Arith_OUT), 35);
    step(0, 50, 15, 4'b0010);
    chk("mul750", int'(Arith_OUT), 750);
    step(0, 255, 255, 4'b0010);
    chk("mul65025", int'(Arith_OUT), 65025);
    step(0, 255, 255, 4'b0000);
    chk("add510", int'(Arith_OUT), 510);
    chk("add510_cy", int'(Carry_OUT), 1);
    step(0, 10, 50, 4'b0001);
    chk("sub_borrow", int'(Carry_OUT), 1);
    step(0, 50, 5, 4'b0011);
    step(0, 50, 0, 4'b0011);
`ifdef ALU_DIVIDE_EN
    chk("div0", int'(Arith_OUT), 65535);
`else
    chk("div_off", int'(Arith_OUT), 0);
`endif
    step(0, 15, 30, 4'b0100);
    chk("and14", int'(Logic_OUT), 14);
    step(0, 50, 15, 4'b0101);
    chk("or63", int'(Logic_OUT), 63);
    step(0, 50, 15, 4'b0110);
    chk("nand", int'(Logic_OUT), 16'hFFFD);
    step(0, 50, 5, 4'b0111);
    chk("nor", int'(Logic_OUT), 16'hFFC8);
    step(0, 255, 255, 4'b0110);
    chk("nand_ff", int'(Logic_OUT), 16'hFF00);
    step(0, 50, 50, 4'b1001);
    chk("eq", int'(CMP_OUT), 1);
    step(0, 25, 23, 4'b1001);
    step(0, 50, 15, 4'b1010);
    chk("gt", int'(CMP_OUT), 2);
    step(0, 240, 245, 4'b1010);
    step(0, 10, 50, 4'b1011);
    chk("lt", int'(CMP_OUT), 3);
    step(0, 50, 5, 4'b1011);
    step(0, 50, 5, 4'b1000);
    step(0, 40, 0, 4'b1100);
    step(0, 255, 0, 4'b1100);
    chk("shr127", int'(SHIFT_OUT), 127);
    step(0, 50, 0, 4'b1101);
    step(0, 255, 0, 4'b1101);
    chk("shl510", int'(SHIFT_OUT), 510);
    step(0, 0, 80, 4'b1110);
    chk("bshr40", int'(SHIFT_OUT), 40);
    step(0, 0, 5, 4'b1111);
    step(0, 0, 255, 4'b1111);
    step(1, 50, 15, 4'b0010);
    chk("mid_rst", int'(Arith_OUT), 0);
    step(0, 50, 15, 4'b0010);
    chk("post_rst", int'(Arith_OUT), 750);

    for (int i = 0; i < 300; i++) begin
      int ra;
      int rb;
      ra = int'($urandom_range(0, 255));
      rb = int'($urandom_range(0, 255));
      if ($urandom_range(0, 7) == 0) rb = 0;
      if ($urandom_range(0, 7) == 0) ra = 255;
      step(($urandom_range(0, 19) == 0), ra, rb,
           int'($urandom_range(0, 15)));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
